// File: rtl/bp_update_sched.sv
// Branch predictor update scheduler: FIFO of resolved EX outcomes drained into the
// predictor write port, plus a table invalidation walk. Define BPU_PERF_CNT_EN for perf counters.
module bp_update_sched #(
  parameter int  DEPTH       = 4,
  parameter int  BTB_ENTRIES = 16,
  parameter int  PHT_ENTRIES = 16,
  localparam int CLR_N       = (BTB_ENTRIES > PHT_ENTRIES) ? BTB_ENTRIES : PHT_ENTRIES,
  localparam int IDX_W       = $clog2(CLR_N),
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IF_DONE,
  input  logic             MEM_DONE,
  input  logic [1:0]       EX_bType,
  input  logic             EX_rTaken,
  input  logic [31:0]      EX_PC,
  input  logic [31:0]      EX_bTarget,
  input  logic             EX_pTaken,
  input  logic [31:0]      EX_pTarget,
  input  logic             FLUSH_REQ,
  input  logic             BP_ready,
  output logic             EX_mispredict,
  output logic             STALL_REQ,
  output logic             BP_updValid,
  output logic [1:0]       BP_bType,
  output logic             BP_rTaken,
  output logic [31:0]      BP_PC,
  output logic [31:0]      BP_bTarget,
  output logic             BP_clrValid,
  output logic [IDX_W-1:0] BP_clrIdx,
  output logic             FLUSH_BUSY,
  output logic [CNT_W-1:0] Q_count,
  output logic [31:0]      PERF_branches,
  output logic [31:0]      PERF_mispredicts
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {RUN, CLEAR} state_e;

  typedef struct packed {
    logic [1:0]  btype;
    logic        rtaken;
    logic [31:0] pc;
    logic [31:0] target;
  } entry_t;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  entry_t           mem_q [DEPTH];
  entry_t           head_entry;
  logic             adv, br, full, empty, in_run, pop, push;

  assign adv    = IF_DONE && MEM_DONE;
  assign br     = (EX_bType == 2'b01) || (EX_bType == 2'b10);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign in_run = (state_q == RUN);
  assign pop    = BP_updValid && BP_ready;
  // A flush edge discards everything, so a same-cycle EX entry is never written.
  assign push   = in_run && !FLUSH_REQ && adv && br && (!full || pop);

  assign EX_mispredict = br && ((EX_pTaken != EX_rTaken) ||
                                (EX_rTaken && (EX_pTarget != EX_bTarget)));
  assign STALL_REQ     = in_run && br && full && !pop;

  assign head_entry  = mem_q[head_q];
  assign BP_updValid = in_run && !empty;
  // Head fields are masked while empty so unwritten storage never reaches the port.
  assign BP_bType    = BP_updValid ? head_entry.btype  : '0;
  assign BP_rTaken   = BP_updValid ? head_entry.rtaken : 1'b0;
  assign BP_PC       = BP_updValid ? head_entry.pc     : '0;
  assign BP_bTarget  = BP_updValid ? head_entry.target : '0;

  assign BP_clrValid = !in_run;
  assign FLUSH_BUSY  = !in_run;
  assign BP_clrIdx   = clr_idx_q;
  assign Q_count     = count_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      RUN: begin
        if (FLUSH_REQ) begin
          head_d    = '0;
          tail_d    = '0;
          count_d   = '0;
          clr_idx_d = '0;
          state_d   = CLEAR;
        end else begin
          if (push) tail_d = tail_q + PTR_W'(1);
          if (pop)  head_d = head_q + PTR_W'(1);
          unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
          endcase
        end
      end
      CLEAR: begin
        if (FLUSH_REQ) begin
          clr_idx_d = '0;
        end else if (BP_ready) begin
          if (clr_idx_q == IDX_W'(CLR_N - 1)) begin
            clr_idx_d = '0;
            state_d   = RUN;
          end else begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // NOTE: entry storage is left unreset; occupancy alone decides validity and outputs are masked.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{btype: EX_bType, rtaken: EX_rTaken, pc: EX_PC, target: EX_bTarget};
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d, perf_mp_q, perf_mp_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (adv && br && (perf_br_q != '1))            perf_br_d = perf_br_q + 32'd1;
    if (adv && EX_mispredict && (perf_mp_q != '1)) perf_mp_d = perf_mp_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign PERF_branches    = perf_br_q;
  assign PERF_mispredicts = perf_mp_q;
`else
  assign PERF_branches    = '0;
  assign PERF_mispredicts = '0;
`endif

endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Update scheduler for the branch predictor's single write port. It captures resolved branch/JAL outcomes from EX into a small FIFO and drains them into the predictor whenever the predictor accepts a write. It also sequences a full table invalidation walk on a flush request (fence.i / context switch) and flags mispredictions for front-end redirect. It sits between the EX stage and the predictor's update/clear port.

## Interface
- DEPTH, 4, update FIFO entries; power of 2, ≥2
- BTB_ENTRIES, 16, predictor BTB entries
- PHT_ENTRIES, 16, predictor PHT entries
- Derived: CLR_N = max(BTB_ENTRIES, PHT_ENTRIES); IDX_W = $clog2(CLR_N)
---
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- IF_DONE, MEM_DONE  in  1 each  pipeline advances only when both are high
- EX_bType  in  2  00 other, 01 JAL, 10 B-type; 11 treated as 00
- EX_rTaken  in  1  resolved direction
- EX_PC, EX_bTarget  in  32 each  branch PC, resolved target
- EX_pTaken, EX_pTarget  in  1, 32  prediction carried down from IF
- FLUSH_REQ  in  1  invalidate all predictor state
- BP_ready  in  1  predictor accepts an update/clear this cycle
- EX_mispredict  out  1  combinational redirect flag
- STALL_REQ  out  1  hold pipeline; FIFO cannot take the EX entry
- BP_updValid  out  1  update presented
- BP_bType, BP_rTaken, BP_PC, BP_bTarget  out  2/1/32/32  FIFO head fields
- BP_clrValid  out  1  clear of entry BP_clrIdx presented
- BP_clrIdx  out  IDX_W  clear index
- FLUSH_BUSY  out  1  invalidation walk in progress
- Q_count  out  $clog2(DEPTH)+1  FIFO occupancy
- PERF_branches, PERF_mispredicts  out  32 each  performance counters

## Operation
- adv = IF_DONE && MEM_DONE; br = EX_bType ∈ {01,10}.
- EX_mispredict = br && (EX_pTaken != EX_rTaken || (EX_rTaken && EX_pTarget != EX_bTarget)). It is not gated by adv or state.
- FSM has two states, RUN and CLEAR.
- **RUN**
  - pop = BP_updValid && BP_ready.
  - push = adv && br && (!full || pop).
  - STALL_REQ = br && full && !pop. This is combinational from BP_ready.
  - BP_updValid = !empty; the BP_* fields show the head entry.
  - Simultaneous push and pop: Q_count is unchanged. Pointers wrap modulo DEPTH.
  - FLUSH_REQ sampled high: at that edge, empty the FIFO (Q_count→0), drop any same-cycle push, set BP_clrIdx=0, and go to CLEAR.
- **CLEAR**
  - BP_updValid=0, BP_clrValid=1, FLUSH_BUSY=1.
  - Each BP_ready cycle increments BP_clrIdx.
  - Acceptance at index CLR_N-1 returns the FSM to RUN with BP_clrIdx=0.
  - EX entries are dropped, not stalled: push=0 and STALL_REQ=0.
  - FLUSH_REQ sampled high in CLEAR restarts the walk at index 0.
- BP_updValid and BP_clrValid are never high together.

## Timing
- Reset values: FSM=RUN, FIFO empty, all outputs 0 (PERF_* = 0).
- Push to BP_updValid: 1 cycle. An entry pushed at edge k is presented from cycle k+1.
- Flush: FLUSH_REQ at edge k gives FLUSH_BUSY=1 from cycle k+1. With BP_ready held high, FLUSH_BUSY=0 at cycle k+1+CLR_N.
- Reset asserted mid-walk or with a non-empty FIFO aborts immediately to reset values. Entries held in the FIFO are lost.

## Configuration
- BPU_PERF_CNT_EN defined:
  - PERF_branches increments on adv && br.
  - PERF_mispredicts increments on adv && EX_mispredict.
  - Both counters saturate at 32'hFFFF_FFFF and are unaffected by FLUSH_REQ.
- BPU_PERF_CNT_EN undefined: no counter registers; PERF_* are tied to 0.

## Test plan
- Reset, then 4 JALs with adv=1 and BP_ready=0 → Q_count=4. A 5th branch gives STALL_REQ=1 and Q_count stays 4. Setting BP_ready=1 that cycle gives STALL_REQ=0, push and pop together, Q_count=4.
- Push B-type PC=0x100, target=0x140, rTaken=1 → next cycle BP_updValid=1, BP_PC=0x100, BP_bTarget=0x140, BP_bType=10.
- EX_pTaken=1, EX_pTarget=0x200, EX_rTaken=1, EX_bTarget=0x204, bType=10 → EX_mispredict=1. The same case with target 0x200 → EX_mispredict=0.
- 3 entries queued, FLUSH_REQ pulse, BP_ready=1 → next cycle Q_count=0 and BP_clrValid=1. BP_clrIdx steps 0..15 over 16 cycles, then FLUSH_BUSY=0. An EX branch during the walk is dropped and STALL_REQ stays 0.
- FLUSH_REQ again at BP_clrIdx=7 → BP_clrIdx=0 next cycle and the walk runs a full 16 more accepts. Separately, rst_n low mid-walk → all outputs 0 asynchronously.
- With BPU_PERF_CNT_EN: 10 branches, 3 mispredicted, with adv=1 → PERF_branches=10, PERF_mispredicts=3. Without the macro → both 0.
